// File: rtl/core_pkg.sv
// Shared definitions for the ID/EX operand stage of the RV32I core.
//   XLEN / REG_W        : datapath and register-index widths
//   SEL_NONE/MEM/WB     : forwarding-select encodings (bit0 = MEM hit, bit1 = WB hit)
//   stage_state_t       : load-use bubble FSM states
package core_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_WB   = 2'b10;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } stage_state_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ID -> EX bus of the operand stage.
//   id_*  : decoded fields presented by the ID stage (driven by master)
//   ex_*  : registered EX fields and built operands (driven by slave)
//   master: ID-side producer / observer, slave: the id_ex_operand_stage itself
interface id_ex_operand_stage_if #(
    parameter int XLEN = core_pkg::XLEN
);
    localparam int RW = core_pkg::REG_W;

    logic            id_valid;
    logic [RW-1:0]   id_ra;
    logic [RW-1:0]   id_rb;
    logic [RW-1:0]   id_rd;
    logic            id_we;
    logic            id_mb;
    logic            id_is_load;
    logic [XLEN-1:0] id_a;
    logic [XLEN-1:0] id_b;
    logic [XLEN-1:0] id_imm;

    logic            ex_valid;
    logic            ex_we;
    logic            ex_is_load;
    logic [RW-1:0]   ex_ra;
    logic [RW-1:0]   ex_rb;
    logic [RW-1:0]   ex_rd;
    logic            ex_mb;
    logic [XLEN-1:0] ex_op_a;
    logic [XLEN-1:0] ex_op_b;
    logic [XLEN-1:0] ex_store_data;

    modport master (
        output id_valid, id_ra, id_rb, id_rd, id_we, id_mb, id_is_load,
               id_a, id_b, id_imm,
        input  ex_valid, ex_we, ex_is_load, ex_ra, ex_rb, ex_rd, ex_mb,
               ex_op_a, ex_op_b, ex_store_data
    );

    modport slave (
        input  id_valid, id_ra, id_rb, id_rd, id_we, id_mb, id_is_load,
               id_a, id_b, id_imm,
        output ex_valid, ex_we, ex_is_load, ex_ra, ex_rb, ex_rd, ex_mb,
               ex_op_a, ex_op_b, ex_store_data
    );

endinterface

// File: rtl/fwd_operand_mux.sv
// Forwarding operand mux for one EX source operand.
//   idx     : source register index (x0 always reads as zero)
//   sel     : forwarding select, bit0 = MEM hit, bit1 = WB hit (MEM wins)
//   rf_val  : value read from the register file in ID
//   mem_fwd : MEM-stage result, wb_fwd: WB-stage write data
//   val     : resulting operand (purely combinational)
module fwd_operand_mux
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN
) (
    input  logic [REG_W-1:0] idx,
    input  logic [1:0]       sel,
    input  logic [XLEN-1:0]  rf_val,
    input  logic [XLEN-1:0]  mem_fwd,
    input  logic [XLEN-1:0]  wb_fwd,
    output logic [XLEN-1:0]  val
);

    always_comb begin
        val = rf_val;
        if (idx == '0) begin
            val = '0;
        end else if ((sel & SEL_MEM) != SEL_NONE) begin
            // the younger MEM result shadows the WB one
            val = mem_fwd;
        end else if ((sel & SEL_WB) != SEL_NONE) begin
            val = wb_fwd;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and EX operand-select stage.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : id_* decoded fields in, ex_* registered fields and operands out
//   flush             : branch redirect, turns the captured ID instruction into a bubble
//   hold              : global freeze, no register changes
//   a_sel, b_sel      : forwarding selects for rs1 / rs2 (bit0 MEM, bit1 WB)
//   mem_fwd, wb_fwd   : forwarded values
//   lu_stall          : load-use stall request to PC and IF/ID
//   stall_cnt         : saturating count of load-use bubbles inserted
module id_ex_operand_stage #(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    id_ex_operand_stage_if.slave    bus,
    input  logic                    flush,
    input  logic                    hold,
    input  logic [1:0]              a_sel,
    input  logic [1:0]              b_sel,
    input  logic [XLEN-1:0]         mem_fwd,
    input  logic [XLEN-1:0]         wb_fwd,
    output logic                    lu_stall,
    output logic [CNT_W-1:0]        stall_cnt
);
    import core_pkg::*;

    logic             ex_valid_reg;
    logic             ex_we_reg;
    logic             ex_is_load_reg;
    logic             ex_mb_reg;
    logic [REG_W-1:0] ex_ra_reg;
    logic [REG_W-1:0] ex_rb_reg;
    logic [REG_W-1:0] ex_rd_reg;
    logic [XLEN-1:0]  rf_a_reg;
    logic [XLEN-1:0]  rf_b_reg;
    logic [XLEN-1:0]  imm_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    stage_state_t     state_reg;
    stage_state_t     state_next;

    logic             hazard;
    logic             insert_bubble;

    // ---------------- load-use hazard detection ----------------
    always_comb begin
        hazard = ex_valid_reg & ex_is_load_reg & ex_we_reg & (ex_rd_reg != '0) &
                 bus.id_valid &
                 ((bus.id_ra == ex_rd_reg) | (~bus.id_mb & (bus.id_rb == ex_rd_reg)));
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        if (!hold) begin
            if (flush) begin
                state_next = ST_RUN;
            end else if (lu_stall) begin
                state_next = ST_BUBBLE;
            end else begin
                state_next = ST_RUN;
            end
        end
    end

    // ---------------- FSM: outputs ----------------
    // Stall is requested only from RUN, so each load produces at most one bubble;
    // a redirect makes the ID instruction dead, so it never stalls.
    always_comb begin
        lu_stall = 1'b0;
        if (state_reg == ST_RUN) begin
            lu_stall = hazard & ~flush;
        end
    end

    assign insert_bubble = flush | lu_stall;

    // ---------------- ID/EX register bank ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg   <= 1'b0;
            ex_we_reg      <= 1'b0;
            ex_is_load_reg <= 1'b0;
            ex_mb_reg      <= 1'b0;
            ex_ra_reg      <= '0;
            ex_rb_reg      <= '0;
            ex_rd_reg      <= '0;
            rf_a_reg       <= '0;
            rf_b_reg       <= '0;
            imm_reg        <= '0;
        end else if (!hold) begin
            if (insert_bubble) begin
                // bubble is a fully cleared slot so it can never match a hazard or forward
                ex_valid_reg   <= 1'b0;
                ex_we_reg      <= 1'b0;
                ex_is_load_reg <= 1'b0;
                ex_mb_reg      <= 1'b0;
                ex_ra_reg      <= '0;
                ex_rb_reg      <= '0;
                ex_rd_reg      <= '0;
                rf_a_reg       <= '0;
                rf_b_reg       <= '0;
                imm_reg        <= '0;
            end else begin
                ex_valid_reg   <= bus.id_valid;
                ex_we_reg      <= bus.id_we & bus.id_valid;
                ex_is_load_reg <= bus.id_is_load;
                ex_mb_reg      <= bus.id_mb;
                ex_ra_reg      <= bus.id_ra;
                ex_rb_reg      <= bus.id_rb;
                ex_rd_reg      <= bus.id_rd;
                rf_a_reg       <= bus.id_a;
                rf_b_reg       <= bus.id_b;
                imm_reg        <= bus.id_imm;
            end
        end
    end

    // ---------------- stall counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (!hold && lu_stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    // ---------------- operand build ----------------
    // Index 0 is rs1 (operand A), index 1 is rs2 (operand B / store data).
    logic [REG_W-1:0] mux_idx [2];
    logic [1:0]       mux_sel [2];
    logic [XLEN-1:0]  mux_rf  [2];
    logic [XLEN-1:0]  mux_val [2];

    assign mux_idx[0] = ex_ra_reg;
    assign mux_sel[0] = a_sel;
    assign mux_rf[0]  = rf_a_reg;
    assign mux_idx[1] = ex_rb_reg;
    assign mux_sel[1] = b_sel;
    assign mux_rf[1]  = rf_b_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opmux
            fwd_operand_mux #(.XLEN(XLEN)) u_mux (
                .idx     (mux_idx[gi]),
                .sel     (mux_sel[gi]),
                .rf_val  (mux_rf[gi]),
                .mem_fwd (mem_fwd),
                .wb_fwd  (wb_fwd),
                .val     (mux_val[gi])
            );
        end
    endgenerate

    // Store data is always the rs2 value, whatever the immediate select says.
    assign bus.ex_op_a       = mux_val[0];
    assign bus.ex_op_b       = ex_mb_reg ? imm_reg : mux_val[1];
    assign bus.ex_store_data = mux_val[1];

    assign bus.ex_valid   = ex_valid_reg;
    assign bus.ex_we      = ex_we_reg;
    assign bus.ex_is_load = ex_is_load_reg;
    assign bus.ex_ra      = ex_ra_reg;
    assign bus.ex_rb      = ex_rb_reg;
    assign bus.ex_rd      = ex_rd_reg;
    assign bus.ex_mb      = ex_mb_reg;
    assign stall_cnt      = stall_cnt_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage. The stimulus process drives inputs just
// after each rising edge and queues the hand-computed EX state expected for that
// cycle; the monitor samples on the falling edge and compares each queued entry.
// The DUT uses a 2-bit stall counter so saturation is reachable.
module tb_id_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        hold;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [31:0] mem_fwd;
    logic [31:0] wb_fwd;
    logic        lu_stall;
    logic [1:0]  stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    id_ex_operand_stage_if #(.XLEN(32)) bus ();

    id_ex_operand_stage #(.XLEN(32), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flush     (flush),
        .hold      (hold),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .mem_fwd   (mem_fwd),
        .wb_fwd    (wb_fwd),
        .lu_stall  (lu_stall),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic        we;
        logic        ld;
        logic [4:0]  rd;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [31:0] sd;
        logic        lu;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", n, f, act, req);
        end
    endtask

    // monitor: compare everything queued for this cycle on the falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "ex_valid",      {31'd0, bus.ex_valid},   {31'd0, e.v});
            chk(e.name, "ex_we",         {31'd0, bus.ex_we},      {31'd0, e.we});
            chk(e.name, "ex_is_load",    {31'd0, bus.ex_is_load}, {31'd0, e.ld});
            chk(e.name, "ex_rd",         {27'd0, bus.ex_rd},      {27'd0, e.rd});
            chk(e.name, "ex_op_a",       bus.ex_op_a,             e.opa);
            chk(e.name, "ex_op_b",       bus.ex_op_b,             e.opb);
            chk(e.name, "ex_store_data", bus.ex_store_data,       e.sd);
            chk(e.name, "lu_stall",      {31'd0, lu_stall},       {31'd0, e.lu});
            chk(e.name, "stall_cnt",     {30'd0, stall_cnt},      {30'd0, e.cnt});
            $display("[TB] check %-12s ex_valid=%0d rd=%0d op_a=0x%08h op_b=0x%08h sd=0x%08h lu_stall=%0d cnt=%0d",
                     e.name, bus.ex_valid, bus.ex_rd, bus.ex_op_a, bus.ex_op_b,
                     bus.ex_store_data, lu_stall, stall_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [4:0] rd, input logic we, input logic mb, input logic ld,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        bus.id_valid   = v;
        bus.id_ra      = ra;
        bus.id_rb      = rb;
        bus.id_rd      = rd;
        bus.id_we      = we;
        bus.id_mb      = mb;
        bus.id_is_load = ld;
        bus.id_a       = a;
        bus.id_b       = b;
        bus.id_imm     = imm;
    endtask

    task automatic expect_row(input string n, input logic v, input logic we, input logic ld,
                              input logic [4:0] rd, input logic [31:0] opa, input logic [31:0] opb,
                              input logic [31:0] sd, input logic lu, input logic [1:0] cnt);
        exp_t e;
        e.name = n; e.v = v; e.we = we; e.ld = ld; e.rd = rd;
        e.opa = opa; e.opb = opb; e.sd = sd; e.lu = lu; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        hold    = 1'b0;
        a_sel   = 2'b00;
        b_sel   = 2'b00;
        mem_fwd = 32'hAAAA_0000;
        wb_fwd  = 32'h0000_5555;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        step(); step();
        expect_row("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // lw x3, 4(x1)
        step();
        set_id(1, 1, 0, 3, 1, 1, 1, 32'h100, 0, 32'h4);
        // add x4, x3, x1 behind the load -> hazard on rs1
        step();
        set_id(1, 3, 1, 4, 1, 0, 0, 32'h30, 32'h11, 0);
        expect_row("lu_lw", 1, 1, 1, 3, 32'h100, 32'h4, 0, 1, 0);
        // bubble in EX; x0 index ignores a forwarding hit
        step();
        a_sel = 2'b10;
        expect_row("lu_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // add enters EX, rs1 from WB; then freeze with new ID contents
        step();
        a_sel = 2'b11; b_sel = 2'b01; hold = 1'b1;
        set_id(1, 7, 8, 9, 1, 1, 1, 32'hDEAD, 32'hBEEF, 32'h77);
        expect_row("fwd_both", 1, 1, 0, 4, 32'hAAAA_0000, 32'hAAAA_0000, 32'hAAAA_0000, 0, 1);
        step();
        a_sel = 2'b10; b_sel = 2'b10;
        expect_row("fwd_wb", 1, 1, 0, 4, 32'h5555, 32'h5555, 32'h5555, 0, 1);
        step();
        a_sel = 2'b00; b_sel = 2'b00;
        expect_row("hold_rf", 1, 1, 0, 4, 32'h30, 32'h11, 32'h11, 0, 1);
        step();
        hold = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_row("hold_end", 1, 1, 0, 4, 32'h30, 32'h11, 32'h11, 0, 1);

        // lw x3, 8(x2)
        step();
        set_id(1, 2, 0, 3, 1, 1, 1, 32'h200, 0, 32'h8);
        expect_row("idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // addi x4, x1, 7 with rb field = 3: immediate form, no stall
        step();
        set_id(1, 1, 3, 4, 1, 1, 0, 32'h10, 32'h33, 32'h7);
        expect_row("imm_nostall", 1, 1, 1, 3, 32'h200, 32'h8, 0, 0, 1);
        // lw x6, 12(x2)
        step();
        set_id(1, 2, 0, 6, 1, 1, 1, 32'h40, 0, 32'hC);
        expect_row("addi_ex", 1, 1, 0, 4, 32'h10, 32'h7, 32'h33, 0, 1);
        // addi x5, x6, 7 hazard, but a redirect kills it
        step();
        set_id(1, 6, 0, 5, 1, 1, 0, 32'h66, 0, 32'h7);
        flush = 1'b1;
        expect_row("flush_haz", 1, 1, 1, 6, 32'h40, 32'hC, 0, 0, 1);
        step();
        flush = 1'b0;
        set_id(1, 2, 0, 6, 1, 1, 1, 32'h40, 0, 32'hC);
        expect_row("flush_bub", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // addi x5, x6, 7 behind lw x6 -> stall
        step();
        set_id(1, 6, 0, 5, 1, 1, 0, 32'h66, 0, 32'h7);
        expect_row("imm_stall", 1, 1, 1, 6, 32'h40, 32'hC, 0, 1, 1);
        step();
        expect_row("imm_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 2);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_row("imm_ex", 1, 1, 0, 5, 32'h66, 32'h7, 0, 0, 2);

        // three more lw x7 / add x8,x0,x7 pairs: counter saturates at 3
        for (int k = 0; k < 3; k++) begin
            step();
            set_id(1, 0, 0, 7, 1, 1, 1, 0, 0, 0);
            step();
            set_id(1, 0, 7, 8, 1, 0, 0, 0, 32'h7, 0);
            if (k == 0) hold = 1'b1;
            expect_row("rb_stall", 1, 1, 1, 7, 0, 0, 0, 1, (k == 0) ? 2'd2 : 2'd3);
            if (k == 0) begin
                step();
                hold = 1'b0;
                expect_row("hold_stall", 1, 1, 1, 7, 0, 0, 0, 1, 2);
            end
            step();
            expect_row("rb_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 3);
            step();
            set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            expect_row("rb_ex", 1, 1, 0, 8, 0, 32'h7, 32'h7, 0, 3);
        end

        // reset while a load sits in EX
        step();
        set_id(1, 4, 0, 9, 1, 1, 1, 32'h99, 0, 32'h1);
        step();
        rst_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_row("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        expect_row("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
